// File: rtl/l1_refill_arbiter_pkg.sv
// Shared AXI definitions for the L1 refill path: bus widths, refill burst length
// and the read/write FSM state encodings used by the arbiter and its write buffer.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package l1_refill_arbiter_pkg;

    localparam int AXI_ADDR_W    = `AXI_ADDR_BITS;
    localparam int AXI_DATA_W    = `AXI_DATA_BITS;
    localparam int AXI_STRB_W    = `AXI_STRB_BITS;
    localparam int BEATS_DEFAULT = 4;

    typedef enum logic [2:0] {
        sIDLE,
        sAR_IM,
        sR_IM,
        sAR_DM,
        sR_DM
    } rd_state_t;

    typedef enum logic [1:0] {
        sW_IDLE,
        sW_REQ,
        sW_RESP
    } wr_state_t;

    function automatic int beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/l1_refill_arbiter_if.sv
// Requester-side and shared-master signals of the L1 refill arbiter.
// master = arbiter view, slave = requesters plus memory side.
interface l1_refill_arbiter_if import l1_refill_arbiter_pkg::*; ();

    logic                  im_ARvalid;
    logic [AXI_ADDR_W-1:0] im_read_addr;
    logic                  dm_ARvalid;
    logic [AXI_ADDR_W-1:0] dm_read_addr;
    logic                  dm_AWvalid;
    logic [AXI_ADDR_W-1:0] dm_write_addr;
    logic [AXI_DATA_W-1:0] dm_write_data;
    logic [AXI_STRB_W-1:0] dm_bweb;

    logic                  im_rvalid;
    logic                  dm_rvalid;
    logic                  im_rlast;
    logic                  dm_rlast;
    logic [AXI_DATA_W-1:0] im_rdata;
    logic [AXI_DATA_W-1:0] dm_rdata;
    logic                  dm_write_done;

    logic                  m_ARvalid;
    logic [AXI_ADDR_W-1:0] m_ARaddr;
    logic                  m_ARready;
    logic                  m_Rvalid;
    logic [AXI_DATA_W-1:0] m_Rdata;
    logic                  m_Rlast;
    logic                  m_AWvalid;
    logic [AXI_ADDR_W-1:0] m_AWaddr;
    logic [AXI_DATA_W-1:0] m_Wdata;
    logic [AXI_STRB_W-1:0] m_Wstrb;
    logic                  m_AWready;
    logic                  m_Bvalid;

    modport master (
        input  im_ARvalid, im_read_addr, dm_ARvalid, dm_read_addr,
        input  dm_AWvalid, dm_write_addr, dm_write_data, dm_bweb,
        output im_rvalid, dm_rvalid, im_rlast, dm_rlast, im_rdata, dm_rdata,
        output dm_write_done,
        output m_ARvalid, m_ARaddr,
        input  m_ARready, m_Rvalid, m_Rdata, m_Rlast,
        output m_AWvalid, m_AWaddr, m_Wdata, m_Wstrb,
        input  m_AWready, m_Bvalid
    );

    modport slave (
        output im_ARvalid, im_read_addr, dm_ARvalid, dm_read_addr,
        output dm_AWvalid, dm_write_addr, dm_write_data, dm_bweb,
        input  im_rvalid, dm_rvalid, im_rlast, dm_rlast, im_rdata, dm_rdata,
        input  dm_write_done,
        input  m_ARvalid, m_ARaddr,
        output m_ARready, m_Rvalid, m_Rdata, m_Rlast,
        input  m_AWvalid, m_AWaddr, m_Wdata, m_Wstrb,
        output m_AWready, m_Bvalid
    );

endinterface

// File: rtl/l1_write_buffer.sv
// Single-entry DM write buffer: captures one write, runs the AW/W then B handshake,
// and reports whether a write is still in flight.
//
// state   | meaning
// sW_IDLE | no write outstanding, accepts dm_AWvalid
// sW_REQ  | m_AWvalid held with captured addr/data/strobes until m_AWready
// sW_RESP | AW/W accepted, waiting for m_Bvalid
module l1_write_buffer import l1_refill_arbiter_pkg::*; (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dm_AWvalid,
    input  logic [AXI_ADDR_W-1:0] dm_write_addr,
    input  logic [AXI_DATA_W-1:0] dm_write_data,
    input  logic [AXI_STRB_W-1:0] dm_bweb,
    input  logic                  m_AWready,
    input  logic                  m_Bvalid,
    output logic                  m_AWvalid,
    output logic [AXI_ADDR_W-1:0] m_AWaddr,
    output logic [AXI_DATA_W-1:0] m_Wdata,
    output logic [AXI_STRB_W-1:0] m_Wstrb,
    output logic                  dm_write_done,
    output logic                  wr_idle
);

    wr_state_t             wr_state;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] data_q;
    logic [AXI_STRB_W-1:0] strb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= sW_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
        end else begin
            case (wr_state)
                sW_IDLE: begin
                    if (dm_AWvalid) begin
                        addr_q   <= dm_write_addr;
                        data_q   <= dm_write_data;
                        strb_q   <= dm_bweb;
                        wr_state <= sW_REQ;
                    end
                end
                sW_REQ: begin
                    if (m_AWready) wr_state <= sW_RESP;
                end
                sW_RESP: begin
                    if (m_Bvalid) wr_state <= sW_IDLE;
                end
                default: wr_state <= sW_IDLE;
            endcase
        end
    end

    // Payload is only presented while the request is live so idle/reset outputs read zero.
    assign m_AWvalid     = (wr_state == sW_REQ);
    assign m_AWaddr      = m_AWvalid ? addr_q : '0;
    assign m_Wdata       = m_AWvalid ? data_q : '0;
    assign m_Wstrb       = m_AWvalid ? strb_q : '0;
    assign wr_idle       = (wr_state == sW_IDLE);
    assign dm_write_done = wr_idle && !dm_AWvalid;

endmodule

// File: rtl/l1_refill_arbiter.sv
// Arbitrates IM and DM line refills onto one shared AXI read master and passes
// DM writes through a single-entry write buffer with read-after-write ordering.
//
// state  | meaning
// sIDLE  | no read in flight, picks an eligible pending requester
// sAR_IM | m_ARvalid with the IM line address, waiting for m_ARready
// sR_IM  | read beats routed to IM until m_Rlast
// sAR_DM | m_ARvalid with the DM line address, waiting for m_ARready
// sR_DM  | read beats routed to DM until m_Rlast
module l1_refill_arbiter import l1_refill_arbiter_pkg::*; #(
    parameter int BEATS = BEATS_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    l1_refill_arbiter_if.master bus
);

    localparam int            BW        = beat_cnt_w(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    rd_state_t             rd_state;
    logic                  im_pend;
    logic                  dm_pend;
    logic [AXI_ADDR_W-1:0] im_addr_q;
    logic [AXI_ADDR_W-1:0] dm_addr_q;
    logic                  rr_last_im;
    logic [BW-1:0]         beat_cnt;
    logic                  wr_idle;

    logic in_r;
    logic rd_done;
    logic im_busy;
    logic dm_busy;
    logic im_take;
    logic dm_take;
    logic im_elig;
    logic dm_elig;
    logic grant_im;
    logic grant_dm;

    assign in_r    = (rd_state == sR_IM) || (rd_state == sR_DM);
    assign rd_done = in_r && bus.m_Rvalid && bus.m_Rlast;
    assign im_busy = (rd_state == sAR_IM) || (rd_state == sR_IM);
    assign dm_busy = (rd_state == sAR_DM) || (rd_state == sR_DM);

    // A requester may re-request in the very cycle its own burst finishes.
    assign im_take = bus.im_ARvalid && !im_pend && (!im_busy || (rd_state == sR_IM && rd_done));
    assign dm_take = bus.dm_ARvalid && !dm_pend && (!dm_busy || (rd_state == sR_DM && rd_done));

    // DM reads wait for any outstanding DM write so they observe its data.
    assign im_elig  = im_pend;
    assign dm_elig  = dm_pend && wr_idle;
    assign grant_dm = (rd_state == sIDLE) && dm_elig && (!im_elig || rr_last_im);
    assign grant_im = (rd_state == sIDLE) && im_elig && !grant_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_pend   <= 1'b0;
            dm_pend   <= 1'b0;
            im_addr_q <= '0;
            dm_addr_q <= '0;
        end else begin
            if (grant_im) begin
                im_pend <= 1'b0;
            end else if (im_take) begin
                im_pend   <= 1'b1;
                im_addr_q <= bus.im_read_addr;
            end
            if (grant_dm) begin
                dm_pend <= 1'b0;
            end else if (dm_take) begin
                dm_pend   <= 1'b1;
                dm_addr_q <= bus.dm_read_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state   <= sIDLE;
            rr_last_im <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            case (rd_state)
                sIDLE: begin
                    beat_cnt <= '0;
                    if (grant_dm)      rd_state <= sAR_DM;
                    else if (grant_im) rd_state <= sAR_IM;
                end
                sAR_IM: begin
                    if (bus.m_ARready) rd_state <= sR_IM;
                end
                sAR_DM: begin
                    if (bus.m_ARready) rd_state <= sR_DM;
                end
                sR_IM, sR_DM: begin
                    if (bus.m_Rvalid) begin
                        if (bus.m_Rlast) begin
                            rd_state   <= sIDLE;
                            rr_last_im <= (rd_state == sR_IM);
                            beat_cnt   <= '0;
                        end else if (beat_cnt != LAST_BEAT) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                        // A beat at LAST_BEAT without m_Rlast is a slave protocol error;
                        // the count saturates and only m_Rlast ends the burst.
                    end
                end
                default: rd_state <= sIDLE;
            endcase
        end
    end

    assign bus.m_ARvalid = (rd_state == sAR_IM) || (rd_state == sAR_DM);
    assign bus.m_ARaddr  = (rd_state == sAR_IM) ? im_addr_q :
                           (rd_state == sAR_DM) ? dm_addr_q : '0;

    assign bus.im_rvalid = (rd_state == sR_IM) && bus.m_Rvalid;
    assign bus.im_rlast  = (rd_state == sR_IM) && bus.m_Rlast;
    assign bus.im_rdata  = (rd_state == sR_IM) ? bus.m_Rdata : '0;
    assign bus.dm_rvalid = (rd_state == sR_DM) && bus.m_Rvalid;
    assign bus.dm_rlast  = (rd_state == sR_DM) && bus.m_Rlast;
    assign bus.dm_rdata  = (rd_state == sR_DM) ? bus.m_Rdata : '0;

    l1_write_buffer u_wbuf (
        .clk           (clk),
        .rst           (rst),
        .dm_AWvalid    (bus.dm_AWvalid),
        .dm_write_addr (bus.dm_write_addr),
        .dm_write_data (bus.dm_write_data),
        .dm_bweb       (bus.dm_bweb),
        .m_AWready     (bus.m_AWready),
        .m_Bvalid      (bus.m_Bvalid),
        .m_AWvalid     (bus.m_AWvalid),
        .m_AWaddr      (bus.m_AWaddr),
        .m_Wdata       (bus.m_Wdata),
        .m_Wstrb       (bus.m_Wstrb),
        .dm_write_done (bus.dm_write_done),
        .wr_idle       (wr_idle)
    );

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed bench for l1_refill_arbiter: inputs change on the falling edge and
// outputs are sampled 1ns later, with hand-computed expected values.
module tb_l1_refill_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    l1_refill_arbiter_if bus ();

    l1_refill_arbiter #(.BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic next();
        @(negedge clk);
        bus.im_ARvalid = 1'b0;
        bus.dm_ARvalid = 1'b0;
        bus.dm_AWvalid = 1'b0;
        bus.m_ARready  = 1'b0;
        bus.m_Rvalid   = 1'b0;
        bus.m_Rlast    = 1'b0;
        bus.m_Rdata    = 32'd0;
        bus.m_AWready  = 1'b0;
        bus.m_Bvalid   = 1'b0;
    endtask

    task automatic wait_ar(input string tag, input logic [31:0] addr);
        int n;
        n = 0;
        do begin
            next();
            #1;
            n++;
        end while (!bus.m_ARvalid && n < 20);
        chk({tag, "_valid"}, 32'(bus.m_ARvalid), 32'd1);
        chk({tag, "_addr"}, bus.m_ARaddr, addr);
        bus.m_ARready = 1'b1;
    endtask

    task automatic burst(input logic to_im, input int n, input logic [31:0] base,
                         input logic [31:0] re_addr);
        for (int i = 0; i < n; i++) begin
            next();
            bus.m_Rvalid = 1'b1;
            bus.m_Rdata  = base + 32'(i);
            bus.m_Rlast  = (i == n - 1);
            if (i == n - 1 && re_addr != 32'd0) begin
                if (to_im) begin
                    bus.im_ARvalid = 1'b1; bus.im_read_addr = re_addr;
                end else begin
                    bus.dm_ARvalid = 1'b1; bus.dm_read_addr = re_addr;
                end
            end
            #1;
            chk("rvalid", 32'(to_im ? bus.im_rvalid : bus.dm_rvalid), 32'd1);
            chk("rdata", to_im ? bus.im_rdata : bus.dm_rdata, base + 32'(i));
            chk("rlast", 32'(to_im ? bus.im_rlast : bus.dm_rlast), 32'(i == n - 1));
            chk("other_rvalid", 32'(to_im ? bus.dm_rvalid : bus.im_rvalid), 32'd0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.im_read_addr  = '0;
        bus.dm_read_addr  = '0;
        bus.dm_write_addr = '0;
        bus.dm_write_data = '0;
        bus.dm_bweb       = '0;
        next();
        next();
        #1;
        chk("rst_arvalid", 32'(bus.m_ARvalid), 32'd0);
        chk("rst_araddr", bus.m_ARaddr, 32'd0);
        chk("rst_awvalid", 32'(bus.m_AWvalid), 32'd0);
        chk("rst_awaddr", bus.m_AWaddr, 32'd0);
        chk("rst_wdata", bus.m_Wdata, 32'd0);
        chk("rst_wstrb", 32'(bus.m_Wstrb), 32'd0);
        chk("rst_rvalid", 32'({bus.im_rvalid, bus.dm_rvalid, bus.im_rlast, bus.dm_rlast}), 32'd0);
        chk("rst_im_rdata", bus.im_rdata, 32'd0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
        chk("rst_wdone", 32'(bus.dm_write_done), 32'd1);
        next();
        rst = 1'b0;

        // Tie straight after reset: DM wins; DM re-request on its last beat is kept.
        next();
        bus.im_ARvalid = 1'b1; bus.im_read_addr = 32'h0000_0100;
        bus.dm_ARvalid = 1'b1; bus.dm_read_addr = 32'h2000_0010;
        wait_ar("tie_dm_first", 32'h2000_0010);
        burst(1'b0, 4, 32'h0000_0010, 32'h2000_0030);
        next(); #1;
        chk("tie_idle_gap", 32'(bus.m_ARvalid), 32'd0);
        next(); #1;
        chk("tie_im_ar", 32'(bus.m_ARvalid), 32'd1);
        chk("tie_im_addr", bus.m_ARaddr, 32'h0000_0100);
        bus.m_ARready = 1'b1;
        burst(1'b1, 4, 32'h0000_0020, 32'd0);
        wait_ar("dm_rereq", 32'h2000_0030);
        burst(1'b0, 4, 32'h0000_0040, 32'd0);

        // IM refill with AR accepted two cycles late; repeat pulse while pending is ignored.
        next();
        bus.im_ARvalid = 1'b1; bus.im_read_addr = 32'h0000_1000;
        next();
        bus.im_ARvalid = 1'b1; bus.im_read_addr = 32'h0000_9999;
        #1;
        chk("im_pend_no_ar", 32'(bus.m_ARvalid), 32'd0);
        next(); #1;
        chk("im_ar_valid", 32'(bus.m_ARvalid), 32'd1);
        chk("im_ar_addr", bus.m_ARaddr, 32'h0000_1000);
        next(); #1;
        chk("im_ar_hold", 32'(bus.m_ARvalid), 32'd1);
        next();
        bus.m_ARready = 1'b1;
        #1;
        chk("im_ar_hold2", 32'(bus.m_ARvalid), 32'd1);
        burst(1'b1, 4, 32'h0000_00A0, 32'd0);
        next();
        bus.m_Rvalid = 1'b1; bus.m_Rdata = 32'h5555_5555;
        #1;
        chk("idle_no_route_im", 32'(bus.im_rvalid), 32'd0);
        chk("idle_no_route_dm", 32'(bus.dm_rvalid), 32'd0);

        // DM write then DM read: read held until the write response returns.
        next();
        bus.dm_AWvalid = 1'b1; bus.dm_write_addr = 32'h2000_0000;
        bus.dm_write_data = 32'hDEAD_BEEF; bus.dm_bweb = 4'h3;
        #1;
        chk("wdone_comb_fall", 32'(bus.dm_write_done), 32'd0);
        next();
        bus.dm_ARvalid = 1'b1; bus.dm_read_addr = 32'h2000_0020;
        bus.dm_AWvalid = 1'b1; bus.dm_write_data = 32'h0BAD_0BAD; bus.dm_bweb = 4'hF;
        #1;
        chk("w_awvalid", 32'(bus.m_AWvalid), 32'd1);
        chk("w_awaddr", bus.m_AWaddr, 32'h2000_0000);
        chk("w_wstrb", 32'(bus.m_Wstrb), 32'h3);
        next(); #1;
        chk("w_wdata_kept", bus.m_Wdata, 32'hDEAD_BEEF);
        chk("raw_block1", 32'(bus.m_ARvalid), 32'd0);
        next();
        bus.m_AWready = 1'b1;
        #1;
        chk("raw_block2", 32'(bus.m_ARvalid), 32'd0);
        next(); #1;
        chk("w_resp_awvalid", 32'(bus.m_AWvalid), 32'd0);
        chk("w_resp_wdone", 32'(bus.dm_write_done), 32'd0);
        next();
        bus.m_Bvalid = 1'b1;
        #1;
        chk("raw_block_bvalid", 32'(bus.m_ARvalid), 32'd0);
        next(); #1;
        chk("w_idle_wdone", 32'(bus.dm_write_done), 32'd1);
        chk("raw_idle_gap", 32'(bus.m_ARvalid), 32'd0);
        next(); #1;
        chk("raw_dm_ar", 32'(bus.m_ARvalid), 32'd1);
        chk("raw_dm_addr", bus.m_ARaddr, 32'h2000_0020);
        bus.m_ARready = 1'b1;
        burst(1'b0, 4, 32'h0000_00D0, 32'd0);

        // Outstanding DM write does not stall an IM refill.
        next();
        bus.dm_AWvalid = 1'b1; bus.dm_write_addr = 32'h2000_0040;
        bus.dm_write_data = 32'h1234_5678; bus.dm_bweb = 4'hF;
        bus.im_ARvalid = 1'b1; bus.im_read_addr = 32'h0000_3000;
        next();
        bus.m_AWready = 1'b1;
        #1;
        chk("wim_wdone0", 32'(bus.dm_write_done), 32'd0);
        next(); #1;
        chk("wim_ar", 32'(bus.m_ARvalid), 32'd1);
        chk("wim_addr", bus.m_ARaddr, 32'h0000_3000);
        bus.m_ARready = 1'b1;
        burst(1'b1, 4, 32'h0000_0030, 32'd0);
        next(); #1;
        chk("wim_wdone_after_rd", 32'(bus.dm_write_done), 32'd0);
        next();
        bus.m_Bvalid = 1'b1;
        #1;
        chk("wim_wdone_bvalid", 32'(bus.dm_write_done), 32'd0);
        next(); #1;
        chk("wim_wdone_idle", 32'(bus.dm_write_done), 32'd1);

        // Early m_Rlast on beat 2 ends the burst and clears the beat counter.
        next();
        bus.dm_ARvalid = 1'b1; bus.dm_read_addr = 32'h2000_0080;
        wait_ar("short_ar", 32'h2000_0080);
        burst(1'b0, 2, 32'h0000_0060, 32'd0);
        next(); #1;
        chk("short_beatcnt", 32'(dut.beat_cnt), 32'd0);
        chk("short_idle", 32'(bus.m_ARvalid), 32'd0);

        // Tie with DM granted last: IM wins, DM follows.
        next();
        bus.im_ARvalid = 1'b1; bus.im_read_addr = 32'h0000_0500;
        bus.dm_ARvalid = 1'b1; bus.dm_read_addr = 32'h2000_0090;
        wait_ar("rr_im_first", 32'h0000_0500);
        burst(1'b1, 4, 32'h0000_0070, 32'd0);
        wait_ar("rr_dm_second", 32'h2000_0090);
        burst(1'b0, 4, 32'h0000_0080, 32'd0);

        // Reset during beat 2 of a DM refill, then a clean IM refill.
        next();
        bus.dm_ARvalid = 1'b1; bus.dm_read_addr = 32'h2000_0100;
        wait_ar("mid_ar", 32'h2000_0100);
        next();
        bus.m_Rvalid = 1'b1; bus.m_Rdata = 32'h0000_00E0;
        #1;
        chk("mid_beat1", 32'(bus.dm_rvalid), 32'd1);
        next();
        bus.m_Rvalid = 1'b1; bus.m_Rdata = 32'h0000_00E1;
        rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(bus.dm_rvalid), 32'd0);
        chk("mid_rst_rdata", bus.dm_rdata, 32'd0);
        chk("mid_rst_arvalid", 32'(bus.m_ARvalid), 32'd0);
        chk("mid_rst_wdone", 32'(bus.dm_write_done), 32'd1);
        chk("mid_rst_beatcnt", 32'(dut.beat_cnt), 32'd0);
        next();
        rst = 1'b0;
        next();
        bus.im_ARvalid = 1'b1; bus.im_read_addr = 32'h0000_0600;
        wait_ar("post_rst_ar", 32'h0000_0600);
        burst(1'b1, 4, 32'h0000_00F0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/l1_refill_arbiter.md
L1_REFILL_ARBITER -- requirements
Module: l1_refill_arbiter

Interface
REQ-001 SHALL have parameter BEATS, default 4, meaning beats per cache-line refill burst.
REQ-002 SHALL have the following ports; the one clock is clk and reset is rst, asynchronous and active-high:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- im_ARvalid  in  1  one-cycle IM refill request pulse
- im_read_addr  in  32  IM line address
- dm_ARvalid  in  1  one-cycle DM refill request pulse
- dm_read_addr  in  32  DM line address
- dm_AWvalid  in  1  one-cycle DM write request pulse
- dm_write_addr  in  32  write address
- dm_write_data  in  32  write data
- dm_bweb  in  4  write strobes
- im_rvalid, dm_rvalid  out  1  routed read beat valid
- im_rlast, dm_rlast  out  1  routed last beat
- im_rdata, dm_rdata  out  32  routed read data
- dm_write_done  out  1  high = no DM write in flight
- m_ARvalid  out  1  shared master AR valid
- m_ARaddr  out  32  AR address
- m_ARready  in  1  AR accepted
- m_Rvalid  in  1  read beat valid
- m_Rdata  in  32  read beat data
- m_Rlast  in  1  last read beat
- m_AWvalid  out  1  AW/W valid
- m_AWaddr  out  32  write address
- m_Wdata  out  32  write data
- m_Wstrb  out  4  write strobes
- m_AWready  in  1  AW/W accepted
- m_Bvalid  in  1  write response

Function
REQ-003 SHALL latch each ARvalid pulse into a per-requester pending flag plus address register; the flag clears when that request is granted.
REQ-004 Read FSM SHALL have states sIDLE, sAR_IM, sR_IM, sAR_DM, sR_DM.
REQ-005 From sIDLE with one eligible pending request, the FSM SHALL go to that requester's AR state next cycle. With both eligible, it SHALL grant the requester not granted last (round-robin bit).
REQ-006 In the sAR_x states, m_ARvalid SHALL be 1 and m_ARaddr SHALL be the latched address; the FSM SHALL move to sR_x on m_ARready.
REQ-007 In the sR_x states, m_Rvalid/m_Rdata/m_Rlast SHALL be routed combinationally to the granted requester only; the other requester's rvalid SHALL be 0.
REQ-008 From sR_x, the FSM SHALL return to sIDLE on m_Rvalid && m_Rlast, and the round-robin bit SHALL update then.
REQ-009 A beat counter SHALL count m_Rvalid in sR_x states and clear on return to sIDLE. Beat BEATS-1 without m_Rlast is a protocol error; the FSM SHALL still follow m_Rlast.
REQ-010 A pulse from the requester already pending or granted SHALL be ignored. The pending flag SHALL be set in the same cycle its previous grant ends (sR_x exit).
REQ-011 Write FSM SHALL have states sW_IDLE, sW_REQ, sW_RESP, independent of the read FSM.
REQ-012 dm_AWvalid in sW_IDLE SHALL capture addr/data/strobes and move to sW_REQ; dm_write_done SHALL fall in that same cycle (combinational on dm_AWvalid).
REQ-013 In sW_REQ, m_AWvalid SHALL be 1 until m_AWready; the FSM SHALL then move to sW_RESP. In sW_RESP it SHALL move to sW_IDLE on m_Bvalid.
REQ-014 dm_write_done SHALL be 1 only in sW_IDLE with dm_AWvalid low.
REQ-015 A pending DM read SHALL be ineligible while the write FSM is not in sW_IDLE (read-after-write ordering). IM reads SHALL be unaffected.
REQ-016 dm_AWvalid outside sW_IDLE SHALL be ignored.

Reset
REQ-017 On rst, both FSMs SHALL go to their idle states, and pending flags and the beat counter SHALL clear.
REQ-018 On rst, the round-robin bit SHALL be "IM last", so DM wins the first tie.
REQ-019 Reset values of outputs: all valid/last outputs 0, all data/address outputs 0, dm_write_done 1.
REQ-020 Reset mid-burst SHALL abandon the transaction with no further routing.

Structure
REQ-021 The read-state and write-state enums and the BEATS default SHALL live in the shared AXI definitions package with the existing AXI width macros.
REQ-022 The write path SHALL be a sub-module l1_write_buffer (capture, AW/B handshake, dm_write_done).

Verification
REQ-023 IM pulse at addr 0x0000_1000, m_ARready after 2 cycles, 4 beats -> im_rvalid x4, im_rlast on beat 4, dm_rvalid 0 throughout.
REQ-024 Simultaneous IM 0x100 and DM 0x2000_0010 pulses after reset -> DM granted first; IM AR issued the cycle after the DM last beat returns the FSM to sIDLE.
REQ-025 DM write 0x2000_0000, data 0xDEADBEEF, bweb 0x3; DM read pulse one cycle later -> m_Wstrb=0x3; DM AR not issued until the cycle after m_Bvalid.
REQ-026 DM write outstanding plus IM read -> IM read completes before m_Bvalid; dm_write_done stays 0 until sW_IDLE.
REQ-027 rst asserted during beat 2 of a DM refill -> all outputs at reset values; a new IM request completes normally.
REQ-028 m_Rlast on beat 2 with BEATS=4 -> FSM returns to sIDLE and the beat counter clears.
